// File: rtl/alu_result_buffer.sv
// Two-entry skid buffer behind the ALU result selector; flags are captured at push.
// Optional ALU_RESULT_STATS_EN adds saturating pop and zero-result counters.
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_zero,
`ifdef ALU_RESULT_STATS_EN
  output logic             out_neg,
  output logic [15:0]      res_count,
  output logic [15:0]      zero_count
`else
  output logic             out_neg
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [SEL_W-1:0] sel;
    logic             zero;
    logic             neg;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t r_state;
  ent_t   r_head;
  ent_t   r_tail;
  ent_t   w_new;
  logic   w_push;
  logic   w_pop;

  assign w_new.res  = in_result;
  assign w_new.sel  = in_sel;
  assign w_new.zero = ~|in_result;
  assign w_new.neg  = in_result[WIDTH-1];

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_result = r_head.res;
  assign out_sel    = r_head.sel;
  assign out_zero   = r_head.zero;
  assign out_neg    = r_head.neg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_head  <= w_new;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_head <= w_new;
          end else if (w_push) begin
            r_tail  <= w_new;
            r_state <= FULL;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          // Tail promotes to head; no push can land while full.
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

`ifdef ALU_RESULT_STATS_EN
  logic [15:0] r_res_cnt;
  logic [15:0] r_zero_cnt;

  assign res_count  = r_res_cnt;
  assign zero_count = r_zero_cnt;

  // A pop in a flush cycle was still consumed, so it is counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_cnt  <= '0;
      r_zero_cnt <= '0;
    end else if (w_pop) begin
      if (r_res_cnt != 16'hFFFF)
        r_res_cnt <= r_res_cnt + 16'd1;
      if (r_head.zero && r_zero_cnt != 16'hFFFF)
        r_zero_cnt <= r_zero_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer with a queue scoreboard on the output side.
// Stats checks run only when ALU_RESULT_STATS_EN is defined.
module tb_alu_result_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [2:0]  in_sel;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_sel;
  logic        out_zero;
  logic        out_neg;
`ifdef ALU_RESULT_STATS_EN
  logic [15:0] res_count;
  logic [15:0] zero_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  s;
  } exp_t;

  exp_t q[$];

  logic        hold_prev;
  logic [31:0] hold_res;
  logic [2:0]  hold_sel;

  always #5 clk = ~clk;

  alu_result_buffer #(.WIDTH(32), .SEL_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_sel     (in_sel),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_zero   (out_zero),
`ifdef ALU_RESULT_STATS_EN
    .out_neg    (out_neg),
    .res_count  (res_count),
    .zero_count (zero_count)
`else
    .out_neg    (out_neg)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] r, input logic [2:0] s);
    in_valid  = 1'b1;
    in_result = r;
    in_sel    = s;
    tick();
    in_valid  = 1'b0;
  endtask

  // Scoreboard: compare on pop, then account for reset/flush/push.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (hold_prev && flush === 1'b0) begin
        check("hold_res", out_result, hold_res);
        check("hold_sel", {29'd0, out_sel}, {29'd0, hold_sel});
      end
      if (out_valid && out_ready) begin
        pops++;
        if (q.size() == 0) begin
          check("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("out_result", out_result, e.r);
          check("out_sel", {29'd0, out_sel}, {29'd0, e.s});
          check("out_zero", {31'd0, out_zero}, {31'd0, e.r == 32'd0});
          check("out_neg", {31'd0, out_neg}, {31'd0, e.r[31]});
        end
      end
    end
    if (rst_n !== 1'b1 || flush === 1'b1) begin
      q.delete();
    end else if (in_valid && in_ready) begin
      e.r = in_result;
      e.s = in_sel;
      q.push_back(e);
    end
    hold_prev = (rst_n === 1'b1) && (flush !== 1'b1) && out_valid && !out_ready;
    hold_res  = out_result;
    hold_sel  = out_sel;
  end

  initial begin
    bit acc;
    hold_prev = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_sel    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_zero_neg", {30'd0, out_zero, out_neg}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // single result, one-cycle latency
    out_ready = 1'b1;
    push(32'h0000_0005, 3'b010);
    @(negedge clk);
    check("lat_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat_out_result", out_result, 32'd5);
    tick();
    @(negedge clk);
    check("lat_empty", {31'd0, out_valid}, 32'd0);

    // fill under stall
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push(32'h8000_0000, 3'b001);
    push(32'h0000_0000, 3'b100);
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_head", out_result, 32'h8000_0000);
    check("stall_neg", {31'd0, out_neg}, 32'd1);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("second_head_zero", {31'd0, out_zero}, 32'd1);
    tick();
    @(negedge clk);
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // held input while full
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push(32'h11, 3'd3);
    push(32'h22, 3'd5);
    in_valid  = 1'b1;
    in_result = 32'h1234;
    in_sel    = 3'd6;
    tick();
    tick();
    @(negedge clk);
    check("full_block", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("held_accepted", {31'd0, acc}, 32'd1);
    tick();
    tick();
    @(negedge clk);
    check("held_drained", q.size(), 32'd0);

    // steady ONE with push+pop each cycle
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push(32'd100, 3'd0);
    out_ready = 1'b1;
    for (int v = 1; v <= 10; v++) begin
      in_valid  = 1'b1;
      in_result = v;
      in_sel    = 3'(v);
      @(negedge clk);
      check("one_in_ready", {31'd0, in_ready}, 32'd1);
      check("one_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("one_drained", q.size(), 32'd0);

    // flush while full, input offered
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push(32'hA, 3'd1);
    push(32'hB, 3'd2);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_result = 32'hDEAD;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_full_empty", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);

    // flush in ONE drops the same-cycle push
    @(posedge clk);
    #1;
    push(32'hC, 3'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_result = 32'hBEEF;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_one_empty", {31'd0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("flush_stays_empty", {31'd0, out_valid}, 32'd0);

    // reset while full
    @(posedge clk);
    #1;
    push(32'h8000_0001, 3'd7);
    push(32'h2, 3'd7);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_result = 32'h5555;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_out_result", out_result, 32'd0);
    check("rst2_out_sel", {29'd0, out_sel}, 32'd0);
    check("rst2_flags", {30'd0, out_zero, out_neg}, 32'd0);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

`ifdef ALU_RESULT_STATS_EN
    out_ready = 1'b1;
    push(32'd7, 3'd1);
    push(32'd0, 3'd2);
    push(32'd9, 3'd3);
    tick();
    @(negedge clk);
    check("stats_res", {16'd0, res_count}, 32'd3);
    check("stats_zero", {16'd0, zero_count}, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("stats_flush_res", {16'd0, res_count}, 32'd3);
    check("stats_flush_zero", {16'd0, zero_count}, 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_result = 32'd0;
    in_sel    = 3'd0;
    for (int i = 0; i < 65540; i++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("stats_sat_res", {16'd0, res_count}, 32'h0000FFFF);
    check("stats_sat_zero", {16'd0, zero_count}, 32'h0000FFFF);
`endif

    @(negedge clk);
    check("final_queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
